// File: rtl/hazard_detect_unit.sv
// rtl/hazard_detect_unit.sv - ID-stage RAW hazard detection, IF/ID flush control and bubble counter.
// Optional build macro HAZARD_NOFWD_EN: datapath has no forwarding, so any EX/MEM writer match stalls.
module hazard_detect_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       Op_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic [4:0]       RDaddr_i,
  input  logic             BrTaken_i,
  output logic             NoOp_o,
  output logic             PCWrite_o,
  output logic             Stall_o,
  output logic             Flush_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic             use_rs1, use_rs2, dec_wr, dec_mrd, dec_br;
  logic             match_ex, match_mem, hazard;

  logic [4:0]       ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic             ex_wr_q, ex_wr_d, mem_wr_q, mem_wr_d;
  logic             ex_mrd_q, ex_mrd_d, mem_mrd_q, mem_mrd_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    dec_wr  = 1'b0;
    dec_mrd = 1'b0;
    dec_br  = 1'b0;
    unique case (Op_i)
      OP_R:      begin use_rs1 = 1'b1; use_rs2 = 1'b1; dec_wr = 1'b1; end
      OP_IARITH: begin use_rs1 = 1'b1; dec_wr = 1'b1; end
      OP_LOAD:   begin use_rs1 = 1'b1; dec_wr = 1'b1; dec_mrd = 1'b1; end
      OP_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; dec_br = 1'b1; end
      default:   ;
    endcase
    // x0 is hardwired zero, so writing it never creates a dependency
    if (RDaddr_i == 5'd0) dec_wr = 1'b0;
  end

  always_comb begin
    match_ex  = ex_wr_q  & ((use_rs1 & (RS1addr_i == ex_rd_q))  | (use_rs2 & (RS2addr_i == ex_rd_q)));
    match_mem = mem_wr_q & ((use_rs1 & (RS1addr_i == mem_rd_q)) | (use_rs2 & (RS2addr_i == mem_rd_q)));
    // Branch compare sits in ID and sees no forwarding from EX, nor from a load still in MEM
    hazard = (match_ex & ex_mrd_q)
           | (dec_br & (match_ex | (match_mem & mem_mrd_q)));
`ifdef HAZARD_NOFWD_EN
    hazard = hazard | match_ex | match_mem;
`endif
  end

  always_comb begin
    NoOp_o    = ~rst_i | hazard;
    Stall_o   = rst_i & hazard;
    PCWrite_o = rst_i & ~hazard;
    Flush_o   = rst_i & ~hazard & dec_br & BrTaken_i;
  end

  always_comb begin
    ex_rd_d   = hazard ? 5'd0 : RDaddr_i;
    ex_wr_d   = hazard ? 1'b0 : dec_wr;
    ex_mrd_d  = hazard ? 1'b0 : dec_mrd;
    mem_rd_d  = ex_rd_q;
    mem_wr_d  = ex_wr_q;
    mem_mrd_d = ex_mrd_q;
    stall_cnt_d = stall_cnt_q;
    if (hazard && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_rd_q     <= 5'd0;
      ex_wr_q     <= 1'b0;
      ex_mrd_q    <= 1'b0;
      mem_rd_q    <= 5'd0;
      mem_wr_q    <= 1'b0;
      mem_mrd_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_rd_q     <= ex_rd_d;
      ex_wr_q     <= ex_wr_d;
      ex_mrd_q    <= ex_mrd_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_mrd_q   <= mem_mrd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb/tb_hazard_detect_unit.sv - instruction-level pipeline model checking hazard_detect_unit.
module tb_hazard_detect_unit;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef struct packed {
    logic       v;
    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       tk;
  } ins_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [6:0]  Op_i;
  logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;
  logic        BrTaken_i;
  logic        NoOp_o, PCWrite_o, Stall_o, Flush_o;
  logic [15:0] stall_cnt_o;

  hazard_detect_unit #(.CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .RS1addr_i(RS1addr_i),
    .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i), .BrTaken_i(BrTaken_i),
    .NoOp_o(NoOp_o), .PCWrite_o(PCWrite_o), .Stall_o(Stall_o),
    .Flush_o(Flush_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   errors = 0;
  ins_t ifid, exs, mems;
  ins_t prog[$];
  int   exp_cnt;
  bit   rand_mode;
  int   bub_seen, flush_seen;
  logic prev_flush;

  function automatic ins_t mk(logic [6:0] op, logic [4:0] a, logic [4:0] b, logic [4:0] d, logic t);
    ins_t i;
    i.v = 1'b1; i.op = op; i.rs1 = a; i.rs2 = b; i.rd = d; i.tk = t;
    return i;
  endfunction

  function automatic ins_t nop();
    return mk(OP_I, 5'd0, 5'd0, 5'd0, 1'b0);
  endfunction

  function automatic bit writes(ins_t i);
    return i.v && (i.op == OP_R || i.op == OP_I || i.op == OP_LD) && i.rd != 5'd0;
  endfunction

  function automatic bit reads1(ins_t i);
    return i.op == OP_R || i.op == OP_I || i.op == OP_LD || i.op == OP_ST || i.op == OP_BR;
  endfunction

  function automatic bit reads2(ins_t i);
    return i.op == OP_R || i.op == OP_ST || i.op == OP_BR;
  endfunction

  // consumer c needs a register that producer p has not yet written back
  function automatic bit dep(ins_t c, ins_t p);
    return writes(p) && ((reads1(c) && c.rs1 == p.rd) || (reads2(c) && c.rs2 == p.rd));
  endfunction

  function automatic bit must_stall();
    bit br;
    bit h;
    br = (ifid.op == OP_BR);
    h = (dep(ifid, exs) && exs.op == OP_LD)
      || (br && (dep(ifid, exs) || (dep(ifid, mems) && mems.op == OP_LD)));
`ifdef HAZARD_NOFWD_EN
    h = h || dep(ifid, exs) || dep(ifid, mems);
`endif
    return h;
  endfunction

  function automatic ins_t rand_ins();
    logic [6:0] ops [6];
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD; ops[3] = OP_ST; ops[4] = OP_BR; ops[5] = OP_LUI;
    return mk(ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
  endfunction

  task automatic check1(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    Op_i = ifid.op; RS1addr_i = ifid.rs1; RS2addr_i = ifid.rs2;
    RDaddr_i = ifid.rd; BrTaken_i = ifid.tk;
  endtask

  task automatic step();
    bit h;
    bit fl;
    @(negedge clk_i);
    drive();
    #1;
    h  = must_stall();
    fl = !h && ifid.op == OP_BR && ifid.tk;
    check1("noop", 32'(NoOp_o), 32'(h));
    check1("stall", 32'(Stall_o), 32'(h));
    check1("pcwrite", 32'(PCWrite_o), 32'(!h));
    check1("flush", 32'(Flush_o), 32'(fl));
    check1("flush_consec", 32'(prev_flush & Flush_o), 32'd0);
    prev_flush = Flush_o;
    if (NoOp_o === 1'b1) bub_seen++;
    if (Flush_o === 1'b1) flush_seen++;
    @(posedge clk_i);
    #1;
    mems = exs;
    if (h) begin
      exs = '0;
      exp_cnt++;
    end else begin
      exs = ifid;
      if (fl) ifid = nop();
      else if (prog.size() > 0) ifid = prog.pop_front();
      else if (rand_mode) ifid = rand_ins();
      else ifid = nop();
    end
    check1("stall_cnt", 32'(stall_cnt_o), 32'(exp_cnt));
  endtask

  task automatic run_seq(string tag, int exp_bub, int exp_fl);
    repeat (3) prog.push_back(nop());
    bub_seen = 0;
    flush_seen = 0;
    for (int n = 0; n < 40 && prog.size() > 0; n++) step();
    check1({tag, "_drained"}, 32'(prog.size()), 32'd0);
    check1({tag, "_bubbles"}, 32'(bub_seen), 32'(exp_bub));
    check1({tag, "_flushes"}, 32'(flush_seen), 32'(exp_fl));
  endtask

`ifdef HAZARD_NOFWD_EN
  localparam int NF = 1;
`else
  localparam int NF = 0;
`endif

  initial begin
    rst_i = 1'b0;
    ifid = nop(); exs = '0; mems = '0; exp_cnt = 0;
    rand_mode = 1'b0; prev_flush = 1'b0;
    drive();
    repeat (2) @(posedge clk_i);
    #1;
    check1("rst_noop", 32'(NoOp_o), 32'd1);
    check1("rst_pcwrite", 32'(PCWrite_o), 32'd0);
    check1("rst_stall", 32'(Stall_o), 32'd0);
    check1("rst_flush", 32'(Flush_o), 32'd0);
    check1("rst_cnt", 32'(stall_cnt_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    prog.push_back(mk(OP_LD, 5'd1, 5'd0, 5'd5, 1'b0));
    prog.push_back(mk(OP_R, 5'd5, 5'd1, 5'd6, 1'b0));
    run_seq("lw_use", 1 + NF, 0);
    check1("lw_use_cnt", 32'(stall_cnt_o), 32'(1 + NF));

    prog.push_back(mk(OP_R, 5'd1, 5'd2, 5'd5, 1'b0));
    prog.push_back(mk(OP_BR, 5'd5, 5'd0, 5'd0, 1'b1));
    run_seq("alu_br", 1 + NF, 1);

    prog.push_back(mk(OP_LD, 5'd1, 5'd0, 5'd7, 1'b0));
    prog.push_back(mk(OP_BR, 5'd7, 5'd2, 5'd0, 1'b1));
    run_seq("lw_br", 2, 1);

    prog.push_back(mk(OP_LD, 5'd1, 5'd0, 5'd0, 1'b0));
    prog.push_back(mk(OP_R, 5'd0, 5'd0, 5'd1, 1'b0));
    run_seq("x0", 0, 0);

    prog.push_back(mk(OP_LD, 5'd1, 5'd0, 5'd3, 1'b0));
    prog.push_back(mk(OP_ST, 5'd2, 5'd3, 5'd0, 1'b0));
    run_seq("lw_sw", 1 + NF, 0);

    prog.push_back(mk(OP_R, 5'd1, 5'd2, 5'd5, 1'b0));
    prog.push_back(mk(OP_R, 5'd5, 5'd1, 5'd6, 1'b0));
    run_seq("alu_use", 2 * NF, 0);

    // reset asserted while the load-use bubble is being requested
    prog.push_back(mk(OP_LD, 5'd1, 5'd0, 5'd5, 1'b0));
    prog.push_back(mk(OP_R, 5'd5, 5'd1, 5'd6, 1'b0));
    step();
    step();
    @(negedge clk_i);
    drive();
    #1;
    check1("pre_rst_noop", 32'(NoOp_o), 32'd1);
    #1;
    rst_i = 1'b0;
    #1;
    check1("midrst_noop", 32'(NoOp_o), 32'd1);
    check1("midrst_pcwrite", 32'(PCWrite_o), 32'd0);
    check1("midrst_stall", 32'(Stall_o), 32'd0);
    check1("midrst_flush", 32'(Flush_o), 32'd0);
    check1("midrst_cnt", 32'(stall_cnt_o), 32'd0);
    @(posedge clk_i);
    #1;
    check1("midrst_cnt_hold", 32'(stall_cnt_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    exs = '0; mems = '0; exp_cnt = 0; prev_flush = 1'b0;
    run_seq("post_rst", 0, 0);

    rand_mode = 1'b1;
    repeat (400) step();
    rand_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
